// File: rtl/arf_rat_pkg.sv
// Shared definitions for the architectural register file / register alias table.
// Holds default widths and the per-register alias entry type.
package arf_rat_pkg;

    localparam int N_REGS_DEF     = 32;
    localparam int REG_DATA_WIDTH = 32;
    localparam int ROB_N_ENTRIES  = 16;
    localparam int ROB_ID_WIDTH   = $clog2(ROB_N_ENTRIES);
    localparam int ARF_ID_WIDTH   = $clog2(N_REGS_DEF);

    typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        logic    renamed;
        rob_id_t tag;
    } rat_entry_t;

endpackage

// File: rtl/arf_rat_entry.sv
// One architectural register: committed data plus its alias (renamed bit and ROB tag).
module arf_rat_entry #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_aL,
    input  logic              dispatch_en,
    input  logic [TAG_W-1:0]  dispatch_tag,
    input  logic              retire_en,
    input  logic [TAG_W-1:0]  retire_tag,
    input  logic [DATA_W-1:0] retire_data,
    input  logic              flush,
    output logic [DATA_W-1:0] data,
    output logic              renamed,
    output logic [TAG_W-1:0]  tag
);

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            data    <= '0;
            renamed <= 1'b0;
            tag     <= '0;
        end else begin
            if (retire_en)
                data <= retire_data;
            // Flush beats dispatch; dispatch beats the retire-side clear.
            if (flush) begin
                renamed <= 1'b0;
                tag     <= '0;
            end else if (dispatch_en) begin
                renamed <= 1'b1;
                tag     <= dispatch_tag;
            end else if (retire_en && renamed && (tag == retire_tag)) begin
                renamed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arf_rat.sv
// Architectural register file with integrated register alias table.
// Optional ARF_RAT_RETIRE_BYPASS_EN forwards the retiring value to same-cycle reads.
module arf_rat
    import arf_rat_pkg::*;
#(
    parameter int N_REGS         = N_REGS_DEF,
    parameter int REG_DATA_WIDTH = arf_rat_pkg::REG_DATA_WIDTH,
    parameter int ROB_ID_WIDTH   = $clog2(ROB_N_ENTRIES),
    localparam int AW            = $clog2(N_REGS)
) (
    input  logic                      clk,
    input  logic                      rst_aL,
    input  logic                      dispatch_fire,
    input  logic                      dispatch_dst_valid,
    input  logic [AW-1:0]             dispatch_dst_arf_id,
    input  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id,
    input  logic                      retire,
    input  logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
    input  logic [AW-1:0]             retire_arf_id,
    input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
    input  logic                      flush,
    input  logic [AW-1:0]             arf_id_src1,
    input  logic [AW-1:0]             arf_id_src2,
    output logic                      src1_renamed,
    output logic                      src2_renamed,
    output logic [ROB_ID_WIDTH-1:0]   rob_id_src1,
    output logic [ROB_ID_WIDTH-1:0]   rob_id_src2,
    output logic [REG_DATA_WIDTH-1:0] arf_reg_data_src1,
    output logic [REG_DATA_WIDTH-1:0] arf_reg_data_src2
);

    logic [REG_DATA_WIDTH-1:0] data_q    [N_REGS];
    logic                      renamed_q [N_REGS];
    logic [ROB_ID_WIDTH-1:0]   tag_q     [N_REGS];

    assign data_q[0]    = '0;
    assign renamed_q[0] = 1'b0;
    assign tag_q[0]     = '0;

    // Register 0 is constant; only entries 1..N_REGS-1 hold state.
    for (genvar i = 1; i < N_REGS; i++) begin : g_entry
        arf_rat_entry #(
            .DATA_W (REG_DATA_WIDTH),
            .TAG_W  (ROB_ID_WIDTH)
        ) u_entry (
            .clk          (clk),
            .rst_aL       (rst_aL),
            .dispatch_en  (dispatch_fire && dispatch_dst_valid && (dispatch_dst_arf_id == AW'(i))),
            .dispatch_tag (dispatch_rob_id),
            .retire_en    (retire && (retire_arf_id == AW'(i))),
            .retire_tag   (retire_rob_id),
            .retire_data  (retire_reg_data),
            .flush        (flush),
            .data         (data_q[i]),
            .renamed      (renamed_q[i]),
            .tag          (tag_q[i])
        );
    end

    logic [AW-1:0]             src     [2];
    logic [REG_DATA_WIDTH-1:0] rd_data [2];
    logic                      rd_ren  [2];

    assign src[0] = arf_id_src1;
    assign src[1] = arf_id_src2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = data_q[src[p]];
            rd_ren[p]  = renamed_q[src[p]];
`ifdef ARF_RAT_RETIRE_BYPASS_EN
            // Report the post-edge view of a register that is retiring right now.
            if (retire && (retire_arf_id == src[p]) && (src[p] != '0)) begin
                rd_data[p] = retire_reg_data;
                if (renamed_q[src[p]] && (tag_q[src[p]] == retire_rob_id) &&
                    !(dispatch_fire && dispatch_dst_valid && (dispatch_dst_arf_id == src[p])))
                    rd_ren[p] = 1'b0;
            end
`endif
        end
    end

    assign arf_reg_data_src1 = rd_data[0];
    assign arf_reg_data_src2 = rd_data[1];
    assign src1_renamed      = rd_ren[0];
    assign src2_renamed      = rd_ren[1];
    assign rob_id_src1       = rd_ren[0] ? tag_q[src[0]] : '0;
    assign rob_id_src2       = rd_ren[1] ? tag_q[src[1]] : '0;

endmodule

// File: tb/tb_arf_rat.sv
// Directed self-checking bench for arf_rat with hand-computed expectations.
// Bypass-dependent expectations follow ARF_RAT_RETIRE_BYPASS_EN.
module tb_arf_rat;

    logic        clk = 1'b0;
    logic        rst_aL;
    logic        dispatch_fire, dispatch_dst_valid;
    logic [4:0]  dispatch_dst_arf_id;
    logic [3:0]  dispatch_rob_id;
    logic        retire;
    logic [3:0]  retire_rob_id;
    logic [4:0]  retire_arf_id;
    logic [31:0] retire_reg_data;
    logic        flush;
    logic [4:0]  arf_id_src1, arf_id_src2;
    logic        src1_renamed, src2_renamed;
    logic [3:0]  rob_id_src1, rob_id_src2;
    logic [31:0] arf_reg_data_src1, arf_reg_data_src2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    arf_rat dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .dispatch_fire       (dispatch_fire),
        .dispatch_dst_valid  (dispatch_dst_valid),
        .dispatch_dst_arf_id (dispatch_dst_arf_id),
        .dispatch_rob_id     (dispatch_rob_id),
        .retire              (retire),
        .retire_rob_id       (retire_rob_id),
        .retire_arf_id       (retire_arf_id),
        .retire_reg_data     (retire_reg_data),
        .flush               (flush),
        .arf_id_src1         (arf_id_src1),
        .arf_id_src2         (arf_id_src2),
        .src1_renamed        (src1_renamed),
        .src2_renamed        (src2_renamed),
        .rob_id_src1         (rob_id_src1),
        .rob_id_src2         (rob_id_src2),
        .arf_reg_data_src1   (arf_reg_data_src1),
        .arf_reg_data_src2   (arf_reg_data_src2)
    );

    task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        dispatch_fire = 1'b0; dispatch_dst_valid = 1'b0;
        dispatch_dst_arf_id = '0; dispatch_rob_id = '0;
        retire = 1'b0; retire_rob_id = '0; retire_arf_id = '0; retire_reg_data = '0;
        flush = 1'b0;
    endtask

    task automatic apply_dispatch(input logic [4:0] dst, input logic [3:0] rob);
        dispatch_fire = 1'b1; dispatch_dst_valid = 1'b1;
        dispatch_dst_arf_id = dst; dispatch_rob_id = rob;
    endtask

    task automatic apply_retire(input logic [3:0] rob, input logic [4:0] dst, input logic [31:0] value);
        retire = 1'b1; retire_rob_id = rob; retire_arf_id = dst; retire_reg_data = value;
    endtask

    // Advance one edge, then drop all pulses so each step is a single-cycle event.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_port1(input string name, input logic exp_ren, input logic [3:0] exp_tag, input logic [31:0] exp_data);
        #1;
        check_output({name, ".renamed"}, {31'd0, src1_renamed}, {31'd0, exp_ren});
        check_output({name, ".rob_id"}, {28'd0, rob_id_src1}, {28'd0, exp_tag});
        check_output({name, ".data"}, arf_reg_data_src1, exp_data);
    endtask

    task automatic check_port2(input string name, input logic exp_ren, input logic [3:0] exp_tag, input logic [31:0] exp_data);
        #1;
        check_output({name, ".renamed"}, {31'd0, src2_renamed}, {31'd0, exp_ren});
        check_output({name, ".rob_id"}, {28'd0, rob_id_src2}, {28'd0, exp_tag});
        check_output({name, ".data"}, arf_reg_data_src2, exp_data);
    endtask

    initial begin
        idle_inputs();
        rst_aL = 1'b0;
        arf_id_src1 = 5'd5;
        arf_id_src2 = 5'd31;
        #3;
        check_port1("reset_x5", 1'b0, 4'd0, 32'h0);
        check_port2("reset_x31", 1'b0, 4'd0, 32'h0);
        @(negedge clk);
        rst_aL = 1'b1;

        // Dispatch x5 -> rob 3, then retire it.
        apply_dispatch(5'd5, 4'd3);
        tick();
        check_port1("disp_x5", 1'b1, 4'd3, 32'h0);
        apply_retire(4'd3, 5'd5, 32'hDEADBEEF);
`ifdef ARF_RAT_RETIRE_BYPASS_EN
        check_port1("bypass_x5", 1'b0, 4'd0, 32'hDEADBEEF);
`else
        check_port1("preedge_x5", 1'b1, 4'd3, 32'h0);
`endif
        tick();
        check_port1("retire_x5", 1'b0, 4'd0, 32'hDEADBEEF);

        // Younger writer on x7 keeps the mapping.
        apply_dispatch(5'd7, 4'd2);
        tick();
        apply_dispatch(5'd7, 4'd4);
        tick();
        apply_retire(4'd2, 5'd7, 32'h0000_0077);
        tick();
        arf_id_src1 = 5'd7;
        check_port1("younger_x7", 1'b1, 4'd4, 32'h0000_0077);

        // Same-cycle retire and dispatch on x9.
        apply_dispatch(5'd9, 4'd1);
        tick();
        apply_retire(4'd1, 5'd9, 32'h0000_0099);
        apply_dispatch(5'd9, 4'd6);
        tick();
        arf_id_src1 = 5'd9;
        check_port1("same_cyc_x9", 1'b1, 4'd6, 32'h0000_0099);

        // Flush drops x3, x4, x7, x9 and the same-cycle x10 dispatch; data kept.
        apply_dispatch(5'd3, 4'd7);
        tick();
        apply_dispatch(5'd4, 4'd8);
        tick();
        arf_id_src1 = 5'd3;
        arf_id_src2 = 5'd4;
        check_port1("pre_flush_x3", 1'b1, 4'd7, 32'h0);
        check_port2("pre_flush_x4", 1'b1, 4'd8, 32'h0);
        flush = 1'b1;
        apply_dispatch(5'd10, 4'd9);
        tick();
        check_port1("flush_x3", 1'b0, 4'd0, 32'h0);
        check_port2("flush_x4", 1'b0, 4'd0, 32'h0);
        arf_id_src1 = 5'd10;
        arf_id_src2 = 5'd7;
        check_port1("flush_x10", 1'b0, 4'd0, 32'h0);
        check_port2("flush_x7", 1'b0, 4'd0, 32'h0000_0077);

        // Register 0 ignores dispatch and retire.
        apply_dispatch(5'd0, 4'd5);
        apply_retire(4'd5, 5'd0, 32'h0000_1234);
        arf_id_src1 = 5'd0;
        check_port1("x0_same_cyc", 1'b0, 4'd0, 32'h0);
        tick();
        check_port1("x0_after", 1'b0, 4'd0, 32'h0);

        // Read of a retiring register on both ports.
        apply_dispatch(5'd12, 4'd10);
        tick();
        apply_retire(4'd10, 5'd12, 32'h0000_CAFE);
        arf_id_src1 = 5'd12;
        arf_id_src2 = 5'd12;
`ifdef ARF_RAT_RETIRE_BYPASS_EN
        check_port1("rd_retiring_p1", 1'b0, 4'd0, 32'h0000_CAFE);
        check_port2("rd_retiring_p2", 1'b0, 4'd0, 32'h0000_CAFE);
`else
        check_port1("rd_retiring_p1", 1'b1, 4'd10, 32'h0);
        check_port2("rd_retiring_p2", 1'b1, 4'd10, 32'h0);
`endif
        tick();
        check_port1("retired_x12", 1'b0, 4'd0, 32'h0000_CAFE);

        // Load x31 alias, then assert reset mid-cycle.
        apply_dispatch(5'd31, 4'd11);
        tick();
        arf_id_src1 = 5'd5;
        arf_id_src2 = 5'd31;
        check_port1("loaded_x5", 1'b0, 4'd0, 32'hDEADBEEF);
        check_port2("loaded_x31", 1'b1, 4'd11, 32'h0);
        rst_aL = 1'b0;
        check_port1("midreset_x5", 1'b0, 4'd0, 32'h0);
        check_port2("midreset_x31", 1'b0, 4'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
